// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage MIPS-subset pipeline: widths, reset PC,
// NOP encoding, opcode constants and fetch-decision encoding.
package pipeline_pkg;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned OPCODE_W = 6;
   localparam int unsigned PC_STEP  = 4;

   localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
   localparam logic [OPCODE_W-1:0] OP_HLT   = 6'h3F;

   // What the fetch stage does in a given cycle, in priority order.
   typedef enum logic [1:0] {
      FETCH_HALT     = 2'd0,
      FETCH_STALL    = 2'd1,
      FETCH_REDIRECT = 2'd2,
      FETCH_ADVANCE  = 2'd3
   } fetch_act_e;

   function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1 -: OPCODE_W];
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register holding an instruction, its PC+4 and a valid bit;
// flush dominates hold, and a plain load always marks the entry valid.
module if_id_reg #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                hold,
   input  logic                flush,
   input  logic [31:0]         d_instr,
   input  logic [ADDR_W-1:0]   d_pc4,
   output logic [31:0]         q_instr,
   output logic [ADDR_W-1:0]   q_pc4,
   output logic                q_valid
);
   import pipeline_pkg::*;

   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] pc4_q, pc4_d;
   logic              valid_q, valid_d;

   // Next-state selection: flush > hold > load.
   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (flush) begin
         instr_d = NOP_INSTR;
         pc4_d   = '0;
         valid_d = 1'b0;
      end else if (!hold) begin
         instr_d = d_instr;
         pc4_d   = d_pc4;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= NOP_INSTR;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign q_instr = instr_q;
   assign q_pc4   = pc4_q;
   assign q_valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and feeds the
// IF/ID register; handles stall, redirect, permanent halt and a fetch counter.
module fetch_stage #(
   parameter int unsigned          ADDR_W   = pipeline_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(pipeline_pkg::RESET_PC),
   parameter int unsigned          CNT_W    = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [ADDR_W-1:0]   imem_addr,
   output logic                imem_en,
   input  logic [31:0]         imem_rdata,
   input  logic                stall,
   input  logic                redirect_valid,
   input  logic [ADDR_W-1:0]   redirect_pc,
   input  logic                halt,
   output logic [31:0]         if_id_instr,
   output logic [ADDR_W-1:0]   if_id_pc4,
   output logic                if_id_valid,
   output logic                halted,
   output logic [CNT_W-1:0]    fetch_count
);
   import pipeline_pkg::*;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              halted_q, halted_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] pc_plus4_c;
   logic [ADDR_W-1:0] redirect_aligned_c;
   logic              cnt_full_c;
   fetch_act_e        act_c;
   logic              ifid_hold_c;
   logic              ifid_flush_c;

   assign pc_plus4_c         = pc_q + ADDR_W'(PC_STEP);
   assign redirect_aligned_c = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign cnt_full_c         = (cnt_q == {CNT_W{1'b1}});

   // Priority: halted/halt > stall > redirect > advance.
   always_comb begin
      act_c = FETCH_ADVANCE;
      if (halted_q || halt) begin
         act_c = FETCH_HALT;
      end else if (stall) begin
         act_c = FETCH_STALL;
      end else if (redirect_valid) begin
         act_c = FETCH_REDIRECT;
      end
   end

   always_comb begin
      pc_d         = pc_q;
      halted_d     = halted_q;
      cnt_d        = cnt_q;
      ifid_hold_c  = 1'b0;
      ifid_flush_c = 1'b0;
      unique case (act_c)
         FETCH_HALT: begin
            halted_d     = 1'b1;
            ifid_flush_c = 1'b1;
         end
         FETCH_STALL: begin
            ifid_hold_c = 1'b1;
         end
         FETCH_REDIRECT: begin
            pc_d         = redirect_aligned_c;
            ifid_flush_c = 1'b1;
         end
         FETCH_ADVANCE: begin
            pc_d = pc_plus4_c;
            if (!cnt_full_c) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            ifid_hold_c = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         pc_q     <= pc_d;
         halted_q <= halted_d;
         cnt_q    <= cnt_d;
      end
   end

   if_id_reg #(
      .ADDR_W (ADDR_W)
   ) u_if_id (
      .clk     (clk),
      .rst_n   (rst_n),
      .hold    (ifid_hold_c),
      .flush   (ifid_flush_c),
      .d_instr (imem_rdata),
      .d_pc4   (pc_plus4_c),
      .q_instr (if_id_instr),
      .q_pc4   (if_id_pc4),
      .q_valid (if_id_valid)
   );

   assign imem_addr   = pc_q;
   assign imem_en     = !halted_q && !stall;
   assign halted      = halted_q;
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (default, and wrap/saturation config)
// driven by directed and random control, checked against a per-cycle model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;

   logic [31:0] addr0, addr1, rdata0, rdata1;
   logic        en0, en1;
   logic [31:0] instr0, instr1, pc40, pc41;
   logic        valid0, valid1, halted0, halted1;
   logic [31:0] cnt0;
   logic [3:0]  cnt1;

   logic [31:0] o_addr[2], o_instr[2], o_pc4[2], o_cnt[2];
   logic        o_en[2], o_valid[2], o_halted[2];

   int checks = 0;
   int passes = 0;

   // Model state, one entry per instance.
   logic [31:0] m_pc[2], m_instr[2], m_pc4[2];
   logic        m_valid[2], m_halted[2];
   longint      m_cnt[2];
   longint      cmax[2];
   logic [31:0] rst_pc[2];

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
   endfunction

   assign rdata0 = mem_word(addr0);
   assign rdata1 = mem_word(addr1);

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(addr0), .imem_en(en0), .imem_rdata(rdata0),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
      .if_id_instr(instr0), .if_id_pc4(pc40), .if_id_valid(valid0), .halted(halted0),
      .fetch_count(cnt0)
   );

   fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .CNT_W(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .imem_addr(addr1), .imem_en(en1), .imem_rdata(rdata1),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
      .if_id_instr(instr1), .if_id_pc4(pc41), .if_id_valid(valid1), .halted(halted1),
      .fetch_count(cnt1)
   );

   assign o_addr[0] = addr0;   assign o_addr[1] = addr1;
   assign o_en[0] = en0;       assign o_en[1] = en1;
   assign o_instr[0] = instr0; assign o_instr[1] = instr1;
   assign o_pc4[0] = pc40;     assign o_pc4[1] = pc41;
   assign o_valid[0] = valid0; assign o_valid[1] = valid1;
   assign o_halted[0] = halted0; assign o_halted[1] = halted1;
   assign o_cnt[0] = cnt0;     assign o_cnt[1] = 32'(cnt1);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = rst_pc[k];
         m_instr[k] = 32'h0;
         m_pc4[k] = 32'h0;
         m_valid[k] = 1'b0;
         m_halted[k] = 1'b0;
         m_cnt[k] = 0;
      end
   endtask

   task automatic model_step(input logic s, input logic r, input logic [31:0] rp, input logic h);
      for (int k = 0; k < 2; k++) begin
         if (m_halted[k] || h) begin
            m_halted[k] = 1'b1;
            m_instr[k] = 32'h0; m_pc4[k] = 32'h0; m_valid[k] = 1'b0;
         end else if (s) begin
            // everything holds
         end else if (r) begin
            m_pc[k] = rp & 32'hFFFF_FFFC;
            m_instr[k] = 32'h0; m_pc4[k] = 32'h0; m_valid[k] = 1'b0;
         end else begin
            m_instr[k] = mem_word(m_pc[k]);
            m_pc4[k] = m_pc[k] + 32'd4;
            m_valid[k] = 1'b1;
            m_pc[k] = m_pc[k] + 32'd4;
            m_cnt[k]++;
         end
      end
   endtask

   task automatic check_all(input string phase);
      for (int k = 0; k < 2; k++) begin
         longint ec;
         ec = (m_cnt[k] > cmax[k]) ? cmax[k] : m_cnt[k];
         check($sformatf("%s.%0d.addr", phase, k), o_addr[k], m_pc[k]);
         check($sformatf("%s.%0d.instr", phase, k), o_instr[k], m_instr[k]);
         check($sformatf("%s.%0d.pc4", phase, k), o_pc4[k], m_pc4[k]);
         check($sformatf("%s.%0d.valid", phase, k), 32'(o_valid[k]), 32'(m_valid[k]));
         check($sformatf("%s.%0d.halted", phase, k), 32'(o_halted[k]), 32'(m_halted[k]));
         check($sformatf("%s.%0d.cnt", phase, k), o_cnt[k], 32'(ec));
      end
   endtask

   task automatic cycle(input string phase, input logic s, input logic r,
                        input logic [31:0] rp, input logic h);
      stall = s; redirect_valid = r; redirect_pc = rp; halt = h;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s.%0d.pre_addr", phase, k), o_addr[k], m_pc[k]);
         check($sformatf("%s.%0d.en", phase, k), 32'(o_en[k]), 32'(!m_halted[k] && !s));
      end
      @(posedge clk);
      model_step(s, r, rp, h);
      #1;
      check_all(phase);
   endtask

   initial begin
      rst_pc[0] = 32'h0;          cmax[0] = 64'hFFFF_FFFF;
      rst_pc[1] = 32'hFFFF_FFF8;  cmax[1] = 15;
      rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
      model_reset();

      #12;
      check_all("reset");
      check("wrap_first", addr1, 32'hFFFF_FFF8);
      #8 rst_n = 1'b1;

      // Sequential fetch, then two-cycle stall at pc=8.
      cycle("seq", 0, 0, 0, 0);
      check("wrap_second", addr1, 32'hFFFF_FFFC);
      cycle("seq", 0, 0, 0, 0);
      check("wrap_zero", addr1, 32'h0);
      check("stall_at8", addr0, 32'h8);
      cycle("stall", 1, 0, 0, 0);
      cycle("stall", 1, 0, 0, 0);
      check("stall_hold", addr0, 32'h8);
      cycle("resume", 0, 0, 0, 0);
      cycle("resume", 0, 0, 0, 0);
      check("count4", cnt0, 32'd4);

      // Redirect at pc=0x10 to 0x40, then misaligned 0x43.
      check("pc_0x10", addr0, 32'h10);
      cycle("redir", 0, 1, 32'h40, 0);
      check("redir_bubble", 32'(valid0), 32'h0);
      cycle("redir_next", 0, 0, 0, 0);
      check("redir_instr", instr0, mem_word(32'h40));
      check("redir_pc4", pc40, 32'h44);
      cycle("redir_mis", 0, 1, 32'h43, 0);
      check("redir_align", addr0, 32'h40);

      // Stall with redirect: redirect ignored, then applied alone.
      cycle("fill", 0, 0, 0, 0);
      cycle("stall_redir", 1, 1, 32'h80, 0);
      check("stall_redir_hold", addr0, 32'h44);
      cycle("redir_alone", 0, 1, 32'h80, 0);
      check("redir_alone_pc", addr0, 32'h80);
      cycle("fill", 0, 0, 0, 0);

      // Random traffic; redirects only while IF/ID is valid.
      for (int i = 0; i < 300; i++) begin
         logic s, r;
         s = ($urandom_range(0, 3) == 0);
         r = m_valid[0] && ($urandom_range(0, 9) == 0);
         cycle("rand", s, r, $urandom, 0);
      end

      // Halt pulse, then toggling inputs must be ignored.
      if (!m_valid[0]) cycle("prehalt", 0, 0, 0, 0);
      cycle("halt", 0, 0, 0, 1);
      for (int i = 0; i < 12; i++) begin
         cycle("halted", 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
      end
      check("halted_stays", 32'(halted0), 32'h1);

      // Asynchronous reset mid-cycle, away from any clock edge.
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      check("async_rst_halted", 32'(halted0), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Restart from reset PC and run the small counter into saturation.
      for (int i = 0; i < 20; i++) cycle("post", 0, 0, 0, 0);
      check("sat_cnt", 32'(cnt1), 32'hF);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
